// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Operands and results are registered; one operation is in flight at a time.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | scan requesters from rr_ptr, accept one, latch its operands
// EXEC  | registered operands drive the ALU for one cycle, capture result
// RESP  | present result to the granted requester until rsp_ready
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*WIDTH-1:0] req_op2,
    input  logic [NUM_REQ*3-1:0]     req_ctrl,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [WIDTH-1:0]         alu_operand1,
    output logic [WIDTH-1:0]         alu_operand2,
    output logic [2:0]               alu_alucontrol,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    idx_t               rr_ptr_q, rr_ptr_d;
    idx_t               grant_q, grant_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] req_ready_c;

    logic               found;
    idx_t               pick;
    idx_t               cand;
    logic [WIDTH-1:0]   sel_op1;
    logic [WIDTH-1:0]   sel_op2;
    logic [2:0]         sel_ctrl;
    logic               sel_legal;

    function automatic logic ctrl_legal(input logic [2:0] c);
        case (c)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: ctrl_legal = 1'b1;
            default:                                ctrl_legal = 1'b0;
        endcase
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = idx_t'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        sel_op1   = req_op1[int'(pick)*WIDTH +: WIDTH];
        sel_op2   = req_op2[int'(pick)*WIDTH +: WIDTH];
        sel_ctrl  = req_ctrl[int'(pick)*3 +: 3];
        sel_legal = ctrl_legal(sel_ctrl);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        ctrl_d      = ctrl_q;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        req_ready_c = '0;
        rsp_valid   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c[pick] = 1'b1;
                    grant_d           = pick;
                    if (sel_legal) begin
                        op1_d   = sel_op1;
                        op2_d   = sel_op2;
                        ctrl_d  = sel_ctrl;
                        state_d = EXEC;
                    end else begin
                        result_d = '0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == idx_t'(NUM_REQ - 1)) ? '0 : grant_q + idx_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= 3'b000;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    // Requesters can hold valid through reset; keep ready low while reset is asserted.
    assign req_ready      = req_ready_c & {NUM_REQ{reset_n}};
    assign busy           = (state_q != IDLE);
    assign rsp_result     = result_q;
    assign rsp_zero       = zero_q;
    assign rsp_err        = err_q;
    assign alu_operand1   = op1_q;
    assign alu_operand2   = op2_q;
    assign alu_alucontrol = ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_share_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_op1 = '0;
    logic [N*W-1:0] req_op2 = '0;
    logic [N*3-1:0] req_ctrl = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;
    logic           rsp_err;
    logic           busy;
    logic [W-1:0]   alu_operand1;
    logic [W-1:0]   alu_operand2;
    logic [2:0]     alu_alucontrol;
    logic [W-1:0]   alu_result;
    logic           alu_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_alucontrol(alu_alucontrol),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always_comb begin
        case (alu_alucontrol)
            3'b000:  alu_result = alu_operand1 & alu_operand2;
            3'b001:  alu_result = alu_operand1 | alu_operand2;
            3'b010:  alu_result = alu_operand1 + alu_operand2;
            3'b110:  alu_result = alu_operand1 - alu_operand2;
            3'b111:  alu_result = ($signed(alu_operand1) < $signed(alu_operand2)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] c);
        req_op1[r*W +: W] = a;
        req_op2[r*W +: W] = b;
        req_ctrl[r*3 +: 3] = c;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: ready=%b valid=%b busy=%b required 00 00 0", req_ready, rsp_valid, busy);
        end
        checks++;
        if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: result=%h zero=%b err=%b required 0 0 0", rsp_result, rsp_zero, rsp_err);
        end
        checks++;
        if (alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0 || alu_alucontrol !== 3'b000) begin
            failures++;
            $display("FAIL reset_alu: op1=%h op2=%h ctrl=%b required 0 0 000", alu_operand1, alu_operand2, alu_alucontrol);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] c, input logic [W-1:0] er, input logic ez,
                                  input string nm);
        logic [N-1:0] eg;
        eg = N'(1 << r);
        set_req(r, a, b, c);
        req_valid = eg;
        #1;
        checks++;
        if (req_ready !== eg) begin
            failures++;
            $display("FAIL %s_ready: got %b required %b", nm, req_ready, eg);
        end
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL %s_exec: busy=%b valid=%b ready=%b required 1 00 00", nm, busy, rsp_valid, req_ready);
        end
        checks++;
        if (alu_operand1 !== a || alu_operand2 !== b || alu_alucontrol !== c) begin
            failures++;
            $display("FAIL %s_alu: %h %h %b required %h %h %b", nm, alu_operand1, alu_operand2, alu_alucontrol, a, b, c);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== eg || rsp_result !== er || rsp_zero !== ez || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_rsp: valid=%b result=%h zero=%b err=%b required %b %h %b 0",
                     nm, rsp_valid, rsp_result, rsp_zero, rsp_err, eg, er, ez);
        end
        rsp_ready = eg;
        @(posedge clk); #1;
        rsp_ready = '0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL %s_done: busy=%b valid=%b required 0 00", nm, busy, rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        test_reset();
        set_req(0, 32'hCC, 32'hAA, 3'b010);
        set_req(1, 32'h30, 32'hC0, 3'b111);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL sim_first_grant: got %b required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL sim_exec_ready: got %b required 00", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'h176 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL sim_rsp0: valid=%b result=%h zero=%b required 01 176 0", rsp_valid, rsp_result, rsp_zero);
        end
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL sim_wrong_rsp_ready: valid=%b busy=%b required 01 1", rsp_valid, busy);
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        checks++;
        if (busy !== 1'b0 || req_ready !== 2'b10) begin
            failures++;
            $display("FAIL sim_second_grant: busy=%b ready=%b required 0 10", busy, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL sim_rsp1: valid=%b result=%h zero=%b required 10 1 0", rsp_valid, rsp_result, rsp_zero);
        end
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        // rr_ptr wrapped from 1 back to 0, so requester 0 wins the repeat.
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL sim_repeat_grant: got %b required 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sim_drop: ready=%b busy=%b required 00 0", req_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        set_req(0, 32'hF0, 32'h0F, 3'b001);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b10;
        set_req(1, 32'h1, 32'h2, 3'b010);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'hFF || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b required 01 ff 00",
                         i, rsp_valid, rsp_result, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_release: busy=%b valid=%b ready=%b required 0 00 10", busy, rsp_valid, req_ready);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_withdraw: busy=%b required 0", busy);
        end
    endtask

    task automatic test_illegal();
        set_req(0, 32'h55, 32'h66, 3'b011);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL illegal_rsp: valid=%b err=%b result=%h zero=%b required 01 1 0 0",
                     rsp_valid, rsp_err, rsp_result, rsp_zero);
        end
        checks++;
        if (alu_operand1 !== 32'hF0 || alu_operand2 !== 32'h0F || alu_alucontrol !== 3'b001) begin
            failures++;
            $display("FAIL illegal_alu_hold: %h %h %b required f0 0f 001", alu_operand1, alu_operand2, alu_alucontrol);
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL illegal_done: busy=%b valid=%b required 0 00", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        set_req(1, 32'h1, 32'h1, 3'b010);
        req_valid = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_exec: busy=%b valid=%b required 1 00", busy, rsp_valid);
        end
        req_valid = 2'b11;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 ||
            alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0 || alu_alucontrol !== 3'b000 ||
            rsp_result !== 32'd0 || rsp_err !== 1'b0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: busy=%b valid=%b ready=%b op1=%h op2=%h ctrl=%b result=%h",
                     busy, rsp_valid, req_ready, alu_operand1, alu_operand2, alu_alucontrol, rsp_result);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b00) begin
                failures++;
                $display("FAIL rst_mid_no_rsp: valid=%b required 00", rsp_valid);
            end
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rst_mid_first_grant: got %b required 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_op(0, 32'hCC, 32'hAA, 3'b000, 32'h88, 1'b0, "and_req0");
        test_single_op(1, 32'hCC, 32'hAA, 3'b110, 32'h22, 1'b0, "sub_req1");
        test_single_op(0, 32'hC0, 32'h30, 3'b111, 32'h0, 1'b1, "slt_req0");
        test_simultaneous();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
